serial_rx: RTL and testbench
============================

SERIAL_RX -- requirements
Module: serial_rx

Interface
REQ-001 Parameter OVERSAMPLE, default 16: number of sample ticks per bit period; even values 8..64.
REQ-002 Parameter DATA_BITS, default 8: data bits per frame, sent LSB first.
REQ-003 sysclk  input  1  system clock; all logic on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset, sampled on rising sysclk.
REQ-005 sample_tick_i  input  1  one-sysclk pulse at OVERSAMPLE x baud rate, from the shared baud generator.
REQ-006 receive_i  input  1  asynchronous serial line; idle high.
REQ-007 data_o  output  DATA_BITS  last correctly framed byte.
REQ-008 data_valid_o  output  1  one-cycle pulse; data_o updated this cycle.
REQ-009 framing_error_o  output  1  one-cycle pulse; stop bit sampled low.
REQ-010 busy_o  output  1  high whenever the state machine is not IDLE.

Function
REQ-011 receive_i SHALL pass through a 2-flop synchronizer; all logic uses the second flop (rx_s), plus one delayed copy (rx_d) for edge detection.
REQ-012 States SHALL be IDLE, START, DATA, STOP, using a 2-bit encoding; any unreachable encoding SHALL return to IDLE.
REQ-013 A sample counter (0..OVERSAMPLE-1) and a bit counter (0..DATA_BITS-1) SHALL advance only on cycles with sample_tick_i=1.
REQ-014 IDLE: on rx_d=1 and rx_s=0 (falling edge), go to START and clear the sample counter; a line held low without an edge SHALL NOT start a frame.
REQ-015 START: on the tick where the sample counter reaches OVERSAMPLE/2-1 (mid start bit), if rx_s=1, return to IDLE with no output pulse (glitch reject).
REQ-016 START: if rx_s=0 at that tick, clear both counters and go to DATA.
REQ-017 DATA: on each tick where the sample counter reaches OVERSAMPLE-1 (mid bit), shift rx_s into the MSB of the shift register (right shift) and clear the sample counter.
REQ-018 DATA: after DATA_BITS samples, go to STOP with the sample counter cleared.
REQ-019 STOP: on the tick where the sample counter reaches OVERSAMPLE-1, go to IDLE.
REQ-020 STOP, rx_s=1 at that tick: load data_o from the shift register and pulse data_valid_o on the next cycle.
REQ-021 STOP, rx_s=0 at that tick: pulse framing_error_o instead; data_o SHALL be unchanged.
REQ-022 data_valid_o and framing_error_o SHALL be mutually exclusive and each high for exactly one sysclk.
REQ-023 Only the first stop bit SHALL be checked. Additional stop bits sent by serial_tx (2 per frame) SHALL appear as idle line, and the next falling edge SHALL be accepted.
REQ-024 Without sample_tick_i, state and counters SHALL hold; the synchronizer and edge flops still update every cycle.
REQ-025 End-to-end latency, from the mid-stop-bit tick to data_valid_o, SHALL be 1 sysclk.

Reset
REQ-026 While reset=1 at a rising edge, the block SHALL set:
  - state to IDLE and both counters to 0;
  - synchronizer flops and rx_d to 1;
  - shift register and data_o to 0;
  - data_valid_o, framing_error_o and busy_o to 0.
REQ-027 Reset asserted mid-frame SHALL abandon the frame with no output pulse.
REQ-028 After reset, reception SHALL begin only at a new falling edge.

Verification
REQ-029 serial_tx loopback, OVERSAMPLE=16, byte 0xA5, 2 stop bits -> one data_valid_o pulse, data_o=0xA5, framing_error_o never high.
REQ-030 Back-to-back frames 0x00, 0xFF, 0x3C, no idle gap beyond the stop bits -> three valid pulses in order, data_o matching each byte.
REQ-031 Line low for 3 tick periods, then high -> busy_o rises and falls, no valid or error pulse, data_o unchanged.
REQ-032 Frame 0x55 with the stop bit forced low -> framing_error_o pulse, data_o keeps its previous value, next good frame 0x12 received correctly.
REQ-033 Reset pulsed during data bit 4 of frame 0x81 -> all outputs 0 next cycle, no pulses, and a following frame 0x7E is received correctly.
REQ-034 sample_tick_i gated off for 100 cycles mid-frame -> state held, and the frame completes correctly once ticks resume.

Source files
------------

// File: rtl/serial_rx.sv
// Oversampled UART receiver: 2-flop synchronized line, falling-edge start
// detection, mid-bit sampling, single stop-bit check with valid/error pulses.
module serial_rx #(
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8
) (
  input  logic                 sysclk,
  input  logic                 reset,
  input  logic                 sample_tick_i,
  input  logic                 receive_i,
  output logic [DATA_BITS-1:0] data_o,
  output logic                 data_valid_o,
  output logic                 framing_error_o,
  output logic                 busy_o,
  output logic [1:0]           dbg_state
);

  localparam int SW = $clog2(OVERSAMPLE);
  localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [SW-1:0] MID_START   = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] LAST_SAMPLE = SW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] LAST_BIT    = BW'(DATA_BITS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t               state, state_next;
  logic                 rx_meta, rx_s, rx_d;
  logic [SW-1:0]        sample_cnt, sample_next;
  logic [BW-1:0]        bit_cnt, bit_next;
  logic [DATA_BITS-1:0] shift_reg, shift_next;
  logic                 load_data, valid_next, ferr_next;

  // Synchronizer and edge-detect copy run every cycle, independent of ticks.
  always_ff @(posedge sysclk) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_d    <= 1'b1;
    end else begin
      rx_meta <= receive_i;
      rx_s    <= rx_meta;
      rx_d    <= rx_s;
    end
  end

  always_comb begin
    state_next  = state;
    sample_next = sample_cnt;
    bit_next    = bit_cnt;
    shift_next  = shift_reg;
    load_data   = 1'b0;
    valid_next  = 1'b0;
    ferr_next   = 1'b0;
    case (state)
      IDLE: begin
        if (rx_d && !rx_s) begin
          state_next  = START;
          sample_next = '0;
        end
      end
      START: begin
        if (sample_tick_i) begin
          if (sample_cnt == MID_START) begin
            // A start bit that is high again at its midpoint was a glitch.
            if (rx_s) begin
              state_next = IDLE;
            end else begin
              state_next  = DATA;
              sample_next = '0;
              bit_next    = '0;
            end
          end else begin
            sample_next = sample_cnt + 1'b1;
          end
        end
      end
      DATA: begin
        if (sample_tick_i) begin
          if (sample_cnt == LAST_SAMPLE) begin
            shift_next  = {rx_s, shift_reg[DATA_BITS-1:1]};
            sample_next = '0;
            if (bit_cnt == LAST_BIT) begin
              state_next = STOP;
              bit_next   = '0;
            end else begin
              bit_next = bit_cnt + 1'b1;
            end
          end else begin
            sample_next = sample_cnt + 1'b1;
          end
        end
      end
      STOP: begin
        if (sample_tick_i) begin
          if (sample_cnt == LAST_SAMPLE) begin
            state_next  = IDLE;
            sample_next = '0;
            if (rx_s) begin
              load_data  = 1'b1;
              valid_next = 1'b1;
            end else begin
              ferr_next = 1'b1;
            end
          end else begin
            sample_next = sample_cnt + 1'b1;
          end
        end
      end
      default: begin
        state_next  = IDLE;
        sample_next = '0;
        bit_next    = '0;
      end
    endcase
  end

  always_ff @(posedge sysclk) begin
    if (reset) begin
      state           <= IDLE;
      sample_cnt      <= '0;
      bit_cnt         <= '0;
      shift_reg       <= '0;
      data_o          <= '0;
      data_valid_o    <= 1'b0;
      framing_error_o <= 1'b0;
    end else begin
      state           <= state_next;
      sample_cnt      <= sample_next;
      bit_cnt         <= bit_next;
      shift_reg       <= shift_next;
      data_valid_o    <= valid_next;
      framing_error_o <= ferr_next;
      if (load_data) begin
        data_o <= shift_reg;
      end
    end
  end

  assign busy_o    = (state != IDLE);
  assign dbg_state = state;

endmodule

// File: tb/tb_serial_rx.sv
// Directed + randomized frames driven bit-by-bit from the tick stream; a
// monitor matches every output pulse against an expected-event queue.
module tb_serial_rx;

  localparam int OS       = 16;
  localparam int DB       = 8;
  localparam int W        = DB + 1;
  localparam int TICK_DIV = 4;

  logic          sysclk;
  logic          reset;
  logic          sample_tick_i;
  logic          receive_i;
  logic [DB-1:0] data_o;
  logic          data_valid_o;
  logic          framing_error_o;
  logic          busy_o;
  logic [1:0]    dbg_state;

  int pass_cnt  = 0;
  int fail_cnt  = 0;
  int total_cnt = 0;

  // Expected pulses: bit DB is 1 for a framing error, low bits are the
  // value data_o must show during that pulse.
  logic [W-1:0]  exp_q[$];
  logic [DB-1:0] last_good;
  logic          prev_pulse;

  serial_rx #(.OVERSAMPLE(OS), .DATA_BITS(DB)) dut (
    .sysclk          (sysclk),
    .reset           (reset),
    .sample_tick_i   (sample_tick_i),
    .receive_i       (receive_i),
    .data_o          (data_o),
    .data_valid_o    (data_valid_o),
    .framing_error_o (framing_error_o),
    .busy_o          (busy_o),
    .dbg_state       (dbg_state)
  );

  // Clock / reset
  initial sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  initial begin
    #900000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drivers
  task automatic tick_period();
    repeat (TICK_DIV - 1) @(negedge sysclk);
    sample_tick_i = 1'b1;
    @(negedge sysclk);
    sample_tick_i = 1'b0;
  endtask

  task automatic send_ticks(input int n);
    repeat (n) tick_period();
  endtask

  // One frame: start, DB data bits LSB first, first stop bit (good or low),
  // optional extra low hold, then a second high stop bit.
  task automatic send_frame(input logic [DB-1:0] data, input bit stop_ok,
                            input int low_hold, input int pause_at, input int reset_at);
    logic [1:0] held_state;
    if (reset_at < 0) begin
      if (stop_ok) begin
        last_good = data;
        exp_q.push_back({1'b0, data});
      end else begin
        exp_q.push_back({1'b1, last_good});
      end
    end
    receive_i = 1'b0;
    send_ticks(OS);
    for (int i = 0; i < DB; i++) begin
      receive_i = data[i];
      if (i == 0) begin
        send_ticks(OS / 2);
        check("busy_in_frame", busy_o, 1);
        send_ticks(OS - OS / 2);
      end else if (i == reset_at) begin
        send_ticks(OS / 2);
        receive_i = 1'b1;
        reset = 1'b1;
        @(negedge sysclk);
        check("midreset_data", data_o, 0);
        check("midreset_valid", data_valid_o, 0);
        check("midreset_ferr", framing_error_o, 0);
        check("midreset_busy", busy_o, 0);
        reset = 1'b0;
        last_good = '0;
        send_ticks(2 * OS);
        check("after_reset_idle", busy_o, 0);
        return;
      end else if (i == pause_at) begin
        send_ticks(OS / 2);
        held_state = dbg_state;
        check("busy_before_pause", busy_o, 1);
        repeat (100) @(negedge sysclk);
        check("busy_after_pause", busy_o, 1);
        check("state_held_pause", dbg_state, held_state);
        send_ticks(OS - OS / 2);
      end else begin
        send_ticks(OS);
      end
    end
    receive_i = stop_ok;
    send_ticks(OS);
    if (!stop_ok && low_hold > 0) begin
      send_ticks(low_hold);
      check("low_line_no_start", busy_o, 0);
    end
    receive_i = 1'b1;
    send_ticks(OS);
  endtask

  // Scoreboard monitor
  always @(negedge sysclk) begin
    if (data_valid_o || framing_error_o) begin
      logic [W-1:0] e;
      check("pulse_exclusive", data_valid_o & framing_error_o, 0);
      check("pulse_width", prev_pulse, 0);
      check("pulse_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("pulse_kind_ferr", framing_error_o, e[DB]);
        check("pulse_data_o", data_o, e[DB-1:0]);
      end
    end
    prev_pulse <= data_valid_o | framing_error_o;
  end

  initial begin
    logic [DB-1:0] rnd;
    bit            ok;
    prev_pulse    = 1'b0;
    last_good     = '0;
    reset         = 1'b1;
    sample_tick_i = 1'b0;
    receive_i     = 1'b1;
    repeat (3) @(negedge sysclk);
    check("reset_data", data_o, 0);
    check("reset_valid", data_valid_o, 0);
    check("reset_ferr", framing_error_o, 0);
    check("reset_busy", busy_o, 0);
    reset = 1'b0;
    send_ticks(4);

    // Loopback byte
    send_frame(8'hA5, 1'b1, 0, -1, -1);
    check("a5_drained", exp_q.size(), 0);
    check("a5_data", data_o, 8'hA5);

    // Back-to-back frames
    send_frame(8'h00, 1'b1, 0, -1, -1);
    send_frame(8'hFF, 1'b1, 0, -1, -1);
    send_frame(8'h3C, 1'b1, 0, -1, -1);
    check("b2b_drained", exp_q.size(), 0);
    check("b2b_data", data_o, 8'h3C);

    // Short low glitch
    receive_i = 1'b0;
    send_ticks(3);
    check("glitch_busy_rise", busy_o, 1);
    receive_i = 1'b1;
    send_ticks(10);
    check("glitch_busy_fall", busy_o, 0);
    check("glitch_data_kept", data_o, last_good);
    check("glitch_no_pulse", exp_q.size(), 0);

    // Framing error, long low line afterwards, then a good frame
    send_frame(8'h55, 1'b0, 40, -1, -1);
    check("ferr_data_kept", data_o, 8'h3C);
    send_frame(8'h12, 1'b1, 0, -1, -1);
    check("after_ferr_data", data_o, 8'h12);
    check("ferr_drained", exp_q.size(), 0);

    // Reset during data bit 4, then a clean frame
    send_frame(8'h81, 1'b1, 0, -1, 4);
    check("reset_abandon", exp_q.size(), 0);
    send_frame(8'h7E, 1'b1, 0, -1, -1);
    check("after_reset_data", data_o, 8'h7E);

    // Ticks gated off mid-frame
    send_frame(8'hC3, 1'b1, 0, 3, -1);
    check("pause_data", data_o, 8'hC3);

    // Randomized frames with occasional bad stop bits and idle gaps
    for (int n = 0; n < 12; n++) begin
      rnd = DB'($urandom_range(0, 255));
      ok  = ($urandom_range(0, 4) != 0);
      send_frame(rnd, ok, 0, -1, -1);
      send_ticks($urandom_range(0, 3));
      check("rand_data_o", data_o, last_good);
    end

    send_ticks(2 * OS);
    check("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
